// File: rtl/dm_wait_resp.sv
// dm_wait_resp: multi-cycle data-memory responder for the MEM stage.
// A request is captured in IDLE, held for LATENCY cycles in BUSY, committed
// on the last BUSY edge, and acknowledged with a one-cycle rdy pulse in DONE.
// stall stays high from the presentation cycle until the DONE cycle.
//
// Handshake: the initiator raises re and/or we (we wins when both are high)
// with addr/wrt_data and holds them until it sees rdy. The block samples the
// request only in IDLE, ignores the request lines in BUSY and DONE, and
// pulses rdy for exactly one cycle; the initiator must drop or replace the
// request by the edge that ends the rdy cycle, otherwise it is taken as new.
module dm_wait_resp #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        stall,
    output logic        rdy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter reload value: BUSY lasts LATENCY cycles, counting down to zero.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [15:0]           data_q, data_d;
    logic                  wr_q, wr_d;
    logic [15:0]           rd_data_q, rd_data_d;

    // Backing store; deliberately not reset or initialised.
    logic [15:0]           mem [2**DEPTH_LOG2];

    logic                  accept;
    logic                  commit;

    // Upper address bits alias onto the array and are intentionally dropped.
    if (DEPTH_LOG2 < 16) begin : g_addr_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[15:DEPTH_LOG2];
    end

    assign accept = (state_q == ST_IDLE) && (re || we);
    assign commit = (state_q == ST_BUSY) && (cnt_q == 4'd0);

    // State register; reset abandons any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> BUSY on a request, BUSY -> DONE at count zero,
    // DONE always returns to IDLE regardless of what the initiator presents.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (re || we) state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == 4'd0) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs derived from state; stall also covers the presentation cycle.
    always_comb begin
        stall = 1'b0;
        rdy   = 1'b0;
        case (state_q)
            ST_IDLE: stall = re || we;
            ST_BUSY: stall = 1'b1;
            ST_DONE: rdy   = 1'b1;
            default: begin
                stall = 1'b0;
                rdy   = 1'b0;
            end
        endcase
    end

    // Datapath next values: capture on accept, count in BUSY, load read data
    // on a read commit. Captured values are the only ones used after accept.
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = wr_q;
        rd_data_d = rd_data_q;
        if (accept) begin
            cnt_d  = CNT_LOAD;
            addr_d = addr[DEPTH_LOG2-1:0];
            data_d = wrt_data;
            wr_d   = we;
        end else if (state_q == ST_BUSY && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (commit && !wr_q) begin
            rd_data_d = mem[addr_q];
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            data_q    <= 16'h0000;
            wr_q      <= 1'b0;
            rd_data_q <= 16'h0000;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Write commit into the backing store; a reset before this edge drops it.
    always_ff @(posedge clk) begin
        if (commit && wr_q) begin
            mem[addr_q] <= data_q;
        end
    end

    assign rd_data   = rd_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dm_wait_resp.sv
// Bench for dm_wait_resp: a LATENCY=4 instance and a LATENCY=1 instance,
// checked against a word-addressed memory model with a read-data queue.
module tb_dm_wait_resp;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        re_s      [2];
  logic        we_s      [2];
  logic [15:0] addr_s    [2];
  logic [15:0] wdata_s   [2];
  logic [15:0] rd_data_s [2];
  logic        stall_s   [2];
  logic        rdy_s     [2];
  logic [1:0]  dbg_s     [2];

  dm_wait_resp #(.DEPTH_LOG2(12), .LATENCY(LAT0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr_s[0]),
    .re        (re_s[0]),
    .we        (we_s[0]),
    .wrt_data  (wdata_s[0]),
    .rd_data   (rd_data_s[0]),
    .stall     (stall_s[0]),
    .rdy       (rdy_s[0]),
    .dbg_state (dbg_s[0])
  );

  dm_wait_resp #(.DEPTH_LOG2(12), .LATENCY(LAT1)) u_dut_fast (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr_s[1]),
    .re        (re_s[1]),
    .we        (we_s[1]),
    .wrt_data  (wdata_s[1]),
    .rd_data   (rd_data_s[1]),
    .stall     (stall_s[1]),
    .rdy       (rdy_s[1]),
    .dbg_state (dbg_s[1])
  );

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] mm [int];       // model memory, keyed by instance and word index
  logic [15:0] exp_q [$];      // expected read data, in request order
  logic [15:0] rd_exp [2];     // expected held rd_data per instance

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int key_of(input int d, input logic [15:0] a);
    return d * 65536 + int'(a & 16'h0FFF);
  endfunction

  // ---------------- driver ----------------
  // Presents one request at the next cycle and checks stall/rdy in every
  // cycle of its occupancy. Inputs are scrambled during BUSY to show that
  // only captured values matter; the request is dropped in the DONE cycle.
  task automatic do_req(input int d, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] wd);
    int   lat;
    int   key;
    bit   is_wr;
    bit   known;
    lat   = (d == 0) ? LAT0 : LAT1;
    is_wr = w;
    key   = key_of(d, a);
    known = 1'b1;
    @(posedge clk);
    #1;
    re_s[d]    = r;
    we_s[d]    = w;
    addr_s[d]  = a;
    wdata_s[d] = wd;
    if (!is_wr) begin
      if (mm.exists(key)) exp_q.push_back(mm[key]);
      else known = 1'b0;
    end
    for (int k = 0; k < lat + 2; k++) begin
      @(negedge clk);
      check($sformatf("stall d%0d k%0d", d, k), 32'(stall_s[d]), 32'(k <= lat));
      check($sformatf("rdy d%0d k%0d", d, k), 32'(rdy_s[d]), 32'(k == lat + 1));
      if (k == lat + 1) begin
        if (is_wr) mm[key] = wd;
        else if (known) rd_exp[d] = exp_q.pop_front();
        if (is_wr || known)
          check($sformatf("rd_data d%0d a%h", d, a), 32'(rd_data_s[d]), 32'(rd_exp[d]));
        re_s[d] = 1'b0;
        we_s[d] = 1'b0;
      end else if (k >= 1) begin
        addr_s[d]  = 16'($urandom);
        wdata_s[d] = 16'($urandom);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] a;
    logic [15:0] v;
    for (int d = 0; d < 2; d++) begin
      re_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = 16'h0; wdata_s[d] = 16'h0;
      rd_exp[d] = 16'h0000;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset stall d%0d", d), 32'(stall_s[d]), 32'd0);
      check($sformatf("reset rdy d%0d", d), 32'(rdy_s[d]), 32'd0);
      check($sformatf("reset rd_data d%0d", d), 32'(rd_data_s[d]), 32'h0);
    end
    rst_n = 1'b1;
    idle_cycles(2);

    // Directed: write then read back, LATENCY=4.
    do_req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    // re and we together behave as a write.
    do_req(0, 1'b1, 1'b1, 16'h0020, 16'h1234);
    do_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    // Aliasing of upper address bits.
    do_req(0, 1'b0, 1'b1, 16'h0003, 16'hA5A5);
    do_req(0, 1'b1, 1'b0, 16'hF003, 16'h0000);
    // rd_data held through idle cycles.
    idle_cycles(3);
    @(negedge clk);
    check("rd_data hold idle", 32'(rd_data_s[0]), 32'(rd_exp[0]));

    // Reset mid-write: old contents of 0x0040 must survive.
    do_req(0, 1'b0, 1'b1, 16'h0040, 16'h1111);
    @(posedge clk);
    #1;
    we_s[0] = 1'b1; addr_s[0] = 16'h0040; wdata_s[0] = 16'h2222;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    we_s[0] = 1'b0;
    #1;
    check("async reset stall", 32'(stall_s[0]), 32'd0);
    check("async reset rdy", 32'(rdy_s[0]), 32'd0);
    check("async reset rd_data", 32'(rd_data_s[0]), 32'h0);
    rd_exp[0] = 16'h0000;
    rd_exp[1] = 16'h0000;
    #3;
    rst_n = 1'b1;
    do_req(0, 1'b1, 1'b0, 16'h0040, 16'h0000);

    // LATENCY=1: alternating write/read of word 1, back-to-back.
    for (int i = 1; i <= 8; i++) begin
      do_req(1, 1'b0, 1'b1, 16'h0001, 16'(i));
      do_req(1, 1'b1, 1'b0, 16'h0001, 16'h0000);
    end

    // Random traffic on a small pool of words (pre-written so reads are defined).
    for (int i = 0; i < 8; i++) begin
      do_req(0, 1'b0, 1'b1, 16'h0100 + 16'(i), 16'($urandom));
      do_req(1, 1'b0, 1'b1, 16'h0100 + 16'(i), 16'($urandom));
    end
    for (int i = 0; i < 60; i++) begin
      int d;
      d = $urandom_range(0, 1);
      a = {4'($urandom_range(0, 15)), 12'h100 + 12'($urandom_range(0, 7))};
      v = 16'($urandom);
      case ($urandom_range(0, 2))
        0: do_req(d, 1'b1, 1'b0, a, v);
        1: do_req(d, 1'b0, 1'b1, a, v);
        default: do_req(d, 1'b1, 1'b1, a, v);
      endcase
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    check("exp_q drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
